// File: rtl/iic_bus_conditioner_if.sv
// Controller-side bundle for the I2C bus conditioner: per-channel pad
// drive requests going in, filtered line levels and bus status coming out.
// There is no valid/ready handshake here: every signal is a level or a
// one-cycle pulse, sampled on the rising edge of the conditioner clock.
`timescale 1ns/1ps
interface iic_bus_conditioner_if #(
    parameter int N_CH = 1
);
    logic [N_CH-1:0] iic_scl_o;
    logic [N_CH-1:0] iic_scl_t;
    logic [N_CH-1:0] iic_sda_o;
    logic [N_CH-1:0] iic_sda_t;
    logic [N_CH-1:0] iic_scl_i;
    logic [N_CH-1:0] iic_sda_i;
    logic [N_CH-1:0] bus_busy;
    logic [N_CH-1:0] start_det;
    logic [N_CH-1:0] stop_det;
    logic [N_CH-1:0] stuck_low;

    // I2C controller side
    modport master (
        output iic_scl_o, iic_scl_t, iic_sda_o, iic_sda_t,
        input  iic_scl_i, iic_sda_i, bus_busy, start_det, stop_det, stuck_low
    );

    // conditioner side
    modport slave (
        input  iic_scl_o, iic_scl_t, iic_sda_o, iic_sda_t,
        output iic_scl_i, iic_sda_i, bus_busy, start_det, stop_det, stuck_low
    );
endinterface

// File: rtl/iic_bus_conditioner.sv
// Multi-channel I2C pad conditioner. Each channel owns its open-drain pads,
// a 2-flop synchroniser and stable-count glitch filter per line,
// START/STOP detection on the filtered lines, a bus idle/busy state machine
// and a stuck-low timeout. Channels share nothing except clk and rst.
`timescale 1ns/1ps
module iic_bus_conditioner #(
    parameter int N_CH        = 1,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                clk,
    input  logic                rst,
    iic_bus_conditioner_if.slave bus,
    inout  wire  [N_CH-1:0]     SCL,
    inout  wire  [N_CH-1:0]     SDA
);

    // Filter counter only needs to count to FILTER_LEN-1; the extra +1 keeps
    // the width non-zero when FILTER_LEN is 1.
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] TMO_MAX   = TCW'(TIMEOUT_CYC);

    // Bus state per channel; bus_busy is a direct view of this state.
    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_t;

    logic [N_CH-1:0] scl_filt;
    logic [N_CH-1:0] sda_filt;
    logic [N_CH-1:0] busy_v;
    logic [N_CH-1:0] start_v;
    logic [N_CH-1:0] stop_v;
    logic [N_CH-1:0] stuck_v;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic           scl_s1, scl_s2, sda_s1, sda_s2;
        logic           scl_f, sda_f;
        logic           scl_q, sda_q;
        logic [FCW-1:0] scl_cnt, sda_cnt;
        logic [TCW-1:0] stk_cnt, stk_cnt_nx;
        logic           stk_hit;
        logic           start_c, stop_c;
        logic           start_r, stop_r;
        logic           busy_c;
        bus_state_t     state, state_nx;

        // Open-drain drive: the pad is only ever pulled low, never driven
        // high, and this path is independent of rst.
        assign SCL[c] = (bus.iic_scl_o[c] | bus.iic_scl_t[c]) ? 1'bz : 1'b0;
        assign SDA[c] = (bus.iic_sda_o[c] | bus.iic_sda_t[c]) ? 1'bz : 1'b0;

        // Two-flop synchronisers; the only readers of the raw pads.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                scl_s1 <= 1'b1;
                scl_s2 <= 1'b1;
                sda_s1 <= 1'b1;
                sda_s2 <= 1'b1;
            end else begin
                scl_s1 <= SCL[c];
                scl_s2 <= scl_s1;
                sda_s1 <= SDA[c];
                sda_s2 <= sda_s1;
            end
        end

        // SCL glitch filter: adopt the synced level after FILTER_LEN
        // consecutive cycles of disagreement; any agreement restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                scl_cnt <= '0;
                scl_f   <= 1'b1;
            end else if (scl_s2 == scl_f) begin
                scl_cnt <= '0;
            end else if (scl_cnt == FILT_LAST) begin
                scl_cnt <= '0;
                scl_f   <= scl_s2;
            end else begin
                scl_cnt <= scl_cnt + FCW'(1);
            end
        end

        // SDA glitch filter, same rule as SCL.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sda_cnt <= '0;
                sda_f   <= 1'b1;
            end else if (sda_s2 == sda_f) begin
                sda_cnt <= '0;
            end else if (sda_cnt == FILT_LAST) begin
                sda_cnt <= '0;
                sda_f   <= sda_s2;
            end else begin
                sda_cnt <= sda_cnt + FCW'(1);
            end
        end

        // Previous filtered levels, for edge detection.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                scl_q <= 1'b1;
                sda_q <= 1'b1;
            end else begin
                scl_q <= scl_f;
                sda_q <= sda_f;
            end
        end

        // SCL must be high before and after the SDA edge, so an SCL edge in
        // the same cycle suppresses both conditions.
        assign start_c = scl_q & scl_f &  sda_q & ~sda_f;
        assign stop_c  = scl_q & scl_f & ~sda_q &  sda_f;

        // Condition pulses, registered so they land with the busy update.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                start_r <= 1'b0;
                stop_r  <= 1'b0;
            end else begin
                start_r <= start_c;
                stop_r  <= stop_c;
            end
        end

        // Stuck counter next value: count while either line is low,
        // clear when both are high, hold at the timeout.
        always_comb begin
            stk_cnt_nx = stk_cnt;
            if (scl_f & sda_f) begin
                stk_cnt_nx = '0;
            end else if (stk_cnt != TMO_MAX) begin
                stk_cnt_nx = stk_cnt + TCW'(1);
            end
        end

        assign stk_hit = (stk_cnt_nx == TMO_MAX);

        // Stuck counter register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stk_cnt <= '0;
            end else begin
                stk_cnt <= stk_cnt_nx;
            end
        end

        // Bus state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= BUS_IDLE;
            end else begin
                state <= state_nx;
            end
        end

        // Bus next state: a stuck bus is forced idle; a repeated START keeps
        // it busy.
        always_comb begin
            state_nx = state;
            if (stk_hit) begin
                state_nx = BUS_IDLE;
            end else if (start_c) begin
                state_nx = BUS_BUSY;
            end else if (stop_c) begin
                state_nx = BUS_IDLE;
            end
        end

        // Bus state output decode.
        always_comb begin
            busy_c = (state == BUS_BUSY);
        end

        assign scl_filt[c] = scl_f;
        assign sda_filt[c] = sda_f;
        assign busy_v[c]   = busy_c;
        assign start_v[c]  = start_r;
        assign stop_v[c]   = stop_r;
        assign stuck_v[c]  = (stk_cnt == TMO_MAX);
    end

    assign bus.iic_scl_i = scl_filt;
    assign bus.iic_sda_i = sda_filt;
    assign bus.bus_busy  = busy_v;
    assign bus.start_det = start_v;
    assign bus.stop_det  = stop_v;
    assign bus.stuck_low = stuck_v;

endmodule

// File: doc/iic_bus_conditioner.md
IIC_BUS_CONDITIONER -- requirements
Module: iic_bus_conditioner

Interface
REQ-001 Parameter: N_CH, default 1, number of independent I2C channels (1..16).
REQ-002 Parameter: FILTER_LEN, default 4, consecutive stable cycles required before a filtered line changes (1..15).
REQ-003 Parameter: TIMEOUT_CYC, default 100000, consecutive low cycles on either line before stuck is flagged (>=2).
REQ-004 Port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: iic_scl_o, iic_scl_t  input  N_CH each  SCL output value / tri-state enable from controller.
REQ-007 Port: iic_sda_o, iic_sda_t  input  N_CH each  SDA output value / tri-state enable from controller.
REQ-008 Port: iic_scl_i, iic_sda_i  output  N_CH each  synchronised, glitch-filtered line levels to controller.
REQ-009 Port: SCL, SDA  inout  N_CH each  open-drain pads, one IOBUF per line per channel.
REQ-010 Port: bus_busy  output  N_CH  high between detected START and STOP.
REQ-011 Port: start_det, stop_det  output  N_CH each  one-cycle pulses on START / STOP condition.
REQ-012 Port: stuck_low  output  N_CH  level, high while SCL or SDA held low >= TIMEOUT_CYC cycles.

Function
REQ-013 Pad drive combinational per channel: IOBUF I=0, T = o | t; line pulled low only when o=0 and t=0, otherwise released.
REQ-014 Each pad input passes a 2-flop synchroniser; no other logic reads the raw pad.
REQ-015 Filter per line: counter increments while synced value != filtered value, clears when equal; filtered value takes synced value when counter reaches FILTER_LEN, counter then clears.
REQ-016 Pulse shorter than FILTER_LEN cycles on synced input never reaches iic_*_i; input-to-output latency for a clean edge = 2 + FILTER_LEN cycles.
REQ-017 START: filtered SDA 1->0 while filtered SCL high in both previous and current cycle; start_det pulses 1 cycle, the cycle after the SDA edge is seen.
REQ-018 STOP: filtered SDA 0->1 under same SCL condition; stop_det pulses 1 cycle.
REQ-019 SCL and SDA filtered edges in the same cycle: neither START nor STOP detected.
REQ-020 bus_busy sets on the cycle start_det is high, clears on the cycle stop_det is high; repeated START while busy keeps bus_busy high and still pulses start_det.
REQ-021 Stuck counter per channel: increments while filtered SCL=0 or SDA=0, clears to 0 when both are 1, saturates at TIMEOUT_CYC (no wrap).
REQ-022 stuck_low asserts the cycle the counter reaches TIMEOUT_CYC; deasserts the cycle after both filtered lines are 1; stuck_low also clears bus_busy.
REQ-023 Channels fully independent; no cross-channel state or shared counters.
REQ-024 Counter widths derived by $clog2 of their limits; no truncation at max parameter values.

Reset
REQ-025 On rst: synchroniser flops and filtered outputs = 1 (idle high); iic_scl_i = iic_sda_i = all ones; counters 0; bus_busy, start_det, stop_det, stuck_low = 0.
REQ-026 rst asserted mid-transaction aborts immediately; after release, no START/STOP reported until a new valid edge after filter latency; pad drive (REQ-013) unaffected by rst.

Verification (FILTER_LEN=4, TIMEOUT_CYC=16, N_CH=2 unless stated)
REQ-027 Glitch: 3-cycle low pulse on SDA ch0, SCL high -> iic_sda_i[0] stays 1, no start_det; 6-cycle pulse -> iic_sda_i[0] low 6 cycles after edge, start_det[0] one pulse.
REQ-028 Transaction: START, 9 SCL clocks, STOP on ch1 -> start_det[1] and stop_det[1] one pulse each, bus_busy[1] high between them, ch0 outputs unchanged.
REQ-029 Simultaneous: SCL and SDA both fall in same clock -> no start_det; repeated START while busy -> start_det pulse, bus_busy stays 1.
REQ-030 Stuck: SCL held low 30 cycles -> stuck_low high at cycle 16 + 6 latency, bus_busy cleared; release -> stuck_low low one cycle after filtered SCL=1.
REQ-031 Drive: o=0,t=0 -> pad reads 0; o=1,t=0 or t=1 -> pad high-Z (pulled up to 1); holds during rst.
REQ-032 Reset mid-busy: assert rst while bus_busy=1 -> all status 0, iic_*_i=1 asynchronously; after release with lines idle, no spurious pulses.
